// File: rtl/wbuf_recv.sv
// Weight-buffer receiver: captures X SRAM read data one cycle after each WBUF_EN strobe
// into a double-buffered slot array and presents the active bank to the MAC array.
module wbuf_recv #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NSLOT  = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    WBUF_EN,
  input  logic [5:0]              WBUF_EN_CTRL,
  input  logic                    WBUF_ALL_EN,
  input  logic                    WBUF_PURGE,
  input  logic                    WBUF_SWITCH,
  input  logic [DATA_W-1:0]       DX,
  output logic [NSLOT*DATA_W-1:0] WOUT,
  output logic [NSLOT-1:0]        WVALID,
  output logic [6:0]              FILL_CNT,
  output logic                    FILL_FULL,
  output logic                    BANK,
  output logic                    CTRL_ERR
);

  logic [DATA_W-1:0]      data_q [2][NSLOT];
  logic [1:0][NSLOT-1:0]  valid_q, valid_d;
  logic                   bank_q, bank_d;
  logic                   pend_q, pend_d;
  logic [5:0]             pidx_q, pidx_d;
  logic                   pall_q, pall_d;
  logic                   pbank_q, pbank_d;
  logic                   ctrl_err_q, ctrl_err_d;
  logic [6:0]             fill_cnt_q, fill_cnt_d;
  logic [NSLOT-1:0]       wr_mask;
  logic                   pidx_in_range;

  assign pidx_in_range = ({1'b0, pidx_q} < 7'(NSLOT));

  always_comb begin
    valid_d    = valid_q;
    bank_d     = bank_q;
    ctrl_err_d = ctrl_err_q;
    pend_d     = 1'b0;
    pidx_d     = pidx_q;
    pall_d     = pall_q;
    pbank_d    = pbank_q;
    wr_mask    = '0;
    if (WBUF_PURGE) begin
      // Purge also drops the in-flight write and any strobe issued this cycle.
      valid_d[~bank_q] = '0;
      ctrl_err_d       = 1'b0;
    end else begin
      if (WBUF_SWITCH) begin
        bank_d          = ~bank_q;
        valid_d[bank_q] = '0;
      end
      // Write is applied after the switch clear so an in-flight word always lands.
      if (pend_q) begin
        if (pall_q) begin
          wr_mask = '1;
        end else if (pidx_in_range) begin
          for (int unsigned i = 0; i < NSLOT; i++) begin
            if (pidx_q == 6'(i)) wr_mask[i] = 1'b1;
          end
        end else begin
          ctrl_err_d = 1'b1;
        end
        valid_d[pbank_q] = valid_d[pbank_q] | wr_mask;
      end
      if (WBUF_EN) begin
        pend_d  = 1'b1;
        pidx_d  = WBUF_EN_CTRL;
        pall_d  = WBUF_ALL_EN;
        pbank_d = ~bank_q;
      end
    end
  end

  always_comb begin
    fill_cnt_d = '0;
    for (int unsigned i = 0; i < NSLOT; i++) begin
      fill_cnt_d = fill_cnt_d + 7'(valid_d[~bank_d][i]);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q    <= '0;
      bank_q     <= 1'b0;
      pend_q     <= 1'b0;
      pidx_q     <= '0;
      pall_q     <= 1'b0;
      pbank_q    <= 1'b0;
      ctrl_err_q <= 1'b0;
      fill_cnt_q <= '0;
    end else begin
      valid_q    <= valid_d;
      bank_q     <= bank_d;
      pend_q     <= pend_d;
      pidx_q     <= pidx_d;
      pall_q     <= pall_d;
      pbank_q    <= pbank_d;
      ctrl_err_q <= ctrl_err_d;
      fill_cnt_q <= fill_cnt_d;
    end
  end

  // Data registers carry no reset; stale contents are hidden by the valid mask.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int unsigned i = 0; i < NSLOT; i++) begin
        if (wr_mask[i]) data_q[pbank_q][i] <= DX;
      end
    end
  end

  always_comb begin
    WOUT = '0;
    for (int unsigned i = 0; i < NSLOT; i++) begin
      WOUT[i*DATA_W +: DATA_W] = valid_q[bank_q][i] ? data_q[bank_q][i] : '0;
    end
  end

  assign WVALID    = valid_q[bank_q];
  assign FILL_CNT  = fill_cnt_q;
  assign FILL_FULL = (fill_cnt_q == 7'(NSLOT));
  assign BANK      = bank_q;
  assign CTRL_ERR  = ctrl_err_q;

endmodule

// File: tb/tb_wbuf_recv.sv
// Scoreboard bench for wbuf_recv: a slot-array reference model pushes the expected
// post-edge outputs, and a negedge monitor pops and compares them.
module tb_wbuf_recv;
  localparam int NS = 16;
  localparam int DW = 32;

  logic              CLK = 1'b0;
  logic              RST, WBUF_EN, WBUF_ALL_EN, WBUF_PURGE, WBUF_SWITCH;
  logic [5:0]        WBUF_EN_CTRL;
  logic [DW-1:0]     DX;
  logic [NS*DW-1:0]  WOUT;
  logic [NS-1:0]     WVALID;
  logic [6:0]        FILL_CNT;
  logic              FILL_FULL, BANK, CTRL_ERR;

  wbuf_recv #(.DATA_W(DW), .NSLOT(NS)) dut (
    .CLK(CLK), .RST(RST), .WBUF_EN(WBUF_EN), .WBUF_EN_CTRL(WBUF_EN_CTRL),
    .WBUF_ALL_EN(WBUF_ALL_EN), .WBUF_PURGE(WBUF_PURGE), .WBUF_SWITCH(WBUF_SWITCH),
    .DX(DX), .WOUT(WOUT), .WVALID(WVALID), .FILL_CNT(FILL_CNT), .FILL_FULL(FILL_FULL),
    .BANK(BANK), .CTRL_ERR(CTRL_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic            bank;
    logic [NS-1:0]   wvalid;
    logic [NS*DW-1:0] wout;
    logic [6:0]      cnt;
    logic            full;
    logic            err;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: two banks of slots with per-slot valid flags.
  bit           m_bank;
  bit           m_valid [2][NS];
  logic [DW-1:0] m_data [2][NS];
  bit           m_pend, m_pall, m_pbank, m_err;
  int           m_pidx;

  function automatic exp_t model_out();
    exp_t e;
    int c = 0;
    e.bank = m_bank;
    e.wout = '0;
    for (int i = 0; i < NS; i++) begin
      e.wvalid[i] = m_valid[m_bank][i];
      if (m_valid[m_bank][i]) e.wout[i*DW +: DW] = m_data[m_bank][i];
      if (m_valid[!m_bank][i]) c++;
    end
    e.cnt  = 7'(c);
    e.full = (c == NS);
    e.err  = m_err;
    return e;
  endfunction

  task automatic model_edge(bit rst, bit en, int ctrl, bit all, bit purge, bit sw,
                            logic [DW-1:0] dx);
    bit old_bank = m_bank;
    if (rst) begin
      m_bank = 0; m_pend = 0; m_err = 0;
      for (int i = 0; i < NS; i++) begin m_valid[0][i] = 0; m_valid[1][i] = 0; end
    end else if (purge) begin
      for (int i = 0; i < NS; i++) m_valid[!m_bank][i] = 0;
      m_pend = 0; m_err = 0;
    end else begin
      if (sw) begin
        for (int i = 0; i < NS; i++) m_valid[old_bank][i] = 0;
        m_bank = !old_bank;
      end
      if (m_pend) begin
        if (m_pall) begin
          for (int i = 0; i < NS; i++) begin
            m_data[m_pbank][i] = dx; m_valid[m_pbank][i] = 1;
          end
        end else if (m_pidx < NS) begin
          m_data[m_pbank][m_pidx] = dx; m_valid[m_pbank][m_pidx] = 1;
        end else begin
          m_err = 1;
        end
      end
      m_pend = en; m_pidx = ctrl; m_pall = all; m_pbank = !old_bank;
    end
  endtask

  // Called at posedge+1; drives one cycle of inputs and returns at the next posedge+1.
  task automatic step(bit rst, bit en, int ctrl, bit all, bit purge, bit sw,
                      logic [DW-1:0] dx);
    RST = rst; WBUF_EN = en; WBUF_EN_CTRL = 6'(ctrl); WBUF_ALL_EN = all;
    WBUF_PURGE = purge; WBUF_SWITCH = sw; DX = dx;
    model_edge(rst, en, ctrl, all, purge, sw, dx);
    @(posedge CLK);
    exp_q.push_back(model_out());
    #1;
  endtask

  task automatic idle(logic [DW-1:0] dx);
    step(0, 0, 0, 0, 0, 0, dx);
  endtask

  task automatic chk(string name, logic [DW-1:0] got, logic [DW-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic logic [DW-1:0] slot(int i);
    return WOUT[i*DW +: DW];
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (BANK !== e.bank || WVALID !== e.wvalid || WOUT !== e.wout ||
            FILL_CNT !== e.cnt || FILL_FULL !== e.full || CTRL_ERR !== e.err) begin
          n_bad++;
          $display("FAIL scoreboard @%0t: bank %b/%b wvalid %h/%h cnt %0d/%0d full %b/%b err %b/%b wout_ok=%0b",
                   $time, BANK, e.bank, WVALID, e.wvalid, FILL_CNT, e.cnt, FILL_FULL, e.full,
                   CTRL_ERR, e.err, WOUT === e.wout);
        end
      end
    end
  end

  logic [NS*DW-1:0] saved_wout;

  initial begin
    RST = 1; WBUF_EN = 0; WBUF_EN_CTRL = 0; WBUF_ALL_EN = 0; WBUF_PURGE = 0;
    WBUF_SWITCH = 0; DX = 0;
    m_bank = 0; m_pend = 0; m_pall = 0; m_pbank = 0; m_err = 0; m_pidx = 0;
    @(posedge CLK); #1;
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("reset_bank", 32'(BANK), 0);
    chk("reset_wvalid", 32'(WVALID), 0);
    chk("reset_fill_cnt", 32'(FILL_CNT), 0);
    chk("reset_wout_zero", 32'(WOUT != '0), 0);

    // Fill slots 0..15 back to back, then switch.
    for (int i = 0; i <= NS; i++)
      step(0, i < NS, i, 0, 0, 0, (i > 0) ? DW'(32'h100 + i - 1) : '0);
    chk("fill_cnt_full", 32'(FILL_CNT), 16);
    chk("fill_full_flag", 32'(FILL_FULL), 1);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("switch_bank", 32'(BANK), 1);
    chk("switch_wvalid", 32'(WVALID), 32'hFFFF);
    chk("switch_slot5", slot(5), 32'h105);
    chk("switch_slot15", slot(15), 32'h10F);
    chk("switch_fill_cnt", 32'(FILL_CNT), 0);

    // Broadcast.
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 32'hDEADBEEF);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("bcast_slot0", slot(0), 32'hDEADBEEF);
    chk("bcast_slot15", slot(15), 32'hDEADBEEF);
    chk("bcast_err", 32'(CTRL_ERR), 0);

    // Out-of-range index, then purge.
    step(0, 1, 20, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 32'h55);
    chk("oor_err", 32'(CTRL_ERR), 1);
    chk("oor_fill_cnt", 32'(FILL_CNT), 0);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("purge_clears_err", 32'(CTRL_ERR), 0);

    // Switch while a write is in flight.
    step(0, 1, 3, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'h77);
    chk("inflight_slot3", slot(3), 32'h77);
    chk("inflight_wvalid", 32'(WVALID), 32'h0008);
    chk("inflight_fill_cnt", 32'(FILL_CNT), 0);

    // Purge mid-stream.
    saved_wout = WOUT;
    step(0, 1, 5, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 32'h99);
    idle(32'h99);
    chk("purge_fill_cnt", 32'(FILL_CNT), 0);
    chk("purge_active_kept", 32'(WOUT == saved_wout), 1);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("purge_slot5_absent", 32'(WVALID), 0);

    // Reset mid-stream.
    step(0, 1, 5, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 32'h99);
    chk("rst_bank", 32'(BANK), 0);
    chk("rst_wvalid", 32'(WVALID), 0);
    chk("rst_fill_cnt", 32'(FILL_CNT), 0);
    chk("rst_wout_zero", 32'(WOUT != '0), 0);

    // Partial bank.
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 2, 0, 0, 0, 32'hA0);
    step(0, 0, 0, 0, 0, 0, 32'hA2);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("partial_wvalid", 32'(WVALID), 32'h0005);
    chk("partial_slot1", slot(1), 0);
    chk("partial_slot2", slot(2), 32'hA2);
    chk("partial_slot9", slot(9), 0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 20),
           $urandom_range(0, 9) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 7) == 0, $urandom);
    end
    idle(0);
    idle(0);
    @(negedge CLK); #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
